// File: rtl/wb_stage.sv
// wb_stage: registered write-back stage.
// Captures the MEM bundle, aligns/extends load data, muxes the write-back
// source onto the register-file write port and holds the last committed
// write for one cycle as a bypass source.
// Optional feature macro: WB_RETIRE_CNT_EN (adds the instret counter/port).
module wb_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic [XLEN-1:0]           alu_result,
    input  logic [XLEN-1:0]           pc_plus4,
    input  logic [XLEN-1:0]           csr_rdata,
    input  logic [1:0]                wb_sel,
    input  logic [2:0]                load_type,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      reg_write,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      byp_valid,
    output logic [REG_ADDR_WIDTH-1:0] byp_addr,
    output logic [XLEN-1:0]           byp_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      instret
`endif
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

    logic                      r_valid;
    logic [XLEN-1:0]           r_mem_rdata;
    logic [XLEN-1:0]           r_alu_result;
    logic [XLEN-1:0]           r_pc_plus4;
    logic [XLEN-1:0]           r_csr_rdata;
    logic [1:0]                r_wb_sel;
    logic [2:0]                r_load_type;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_reg_write;
    logic                      r_byp_valid;
    logic [REG_ADDR_WIDTH-1:0] r_byp_addr;
    logic [XLEN-1:0]           r_byp_data;

    logic                      w_capture;
    logic [OFF_W-1:0]          w_off_b;
    logic [OFF_W-1:0]          w_off_h;
    logic [OFF_W-1:0]          w_off_w;
    logic [XLEN-1:0]           w_sh_b;
    logic [XLEN-1:0]           w_sh_h;
    logic [XLEN-1:0]           w_sh_w;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [31:0]               w_word;
    logic [XLEN-1:0]           w_load;
    logic [XLEN-1:0]           w_wdata;
    logic                      w_we;

    assign in_ready  = !stall;
    // flush wins over capture: a bundle offered during flush is dropped
    assign w_capture = in_valid && !stall && !flush;

    // Stage register: capture an accepted bundle, otherwise drop valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_mem_rdata  <= '0;
            r_alu_result <= '0;
            r_pc_plus4   <= '0;
            r_csr_rdata  <= '0;
            r_wb_sel     <= '0;
            r_load_type  <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_mem_rdata  <= mem_rdata;
                r_alu_result <= alu_result;
                r_pc_plus4   <= pc_plus4;
                r_csr_rdata  <= csr_rdata;
                r_wb_sel     <= wb_sel;
                r_load_type  <= load_type;
                r_rd         <= rd_addr;
                r_reg_write  <= reg_write;
            end
        end
    end

    // Lane selection: half and word loads ignore the low offset bits
    assign w_off_b = r_alu_result[OFF_W-1:0];
    assign w_off_h = w_off_b & HALF_MASK;
    assign w_off_w = w_off_b & WORD_MASK;
    assign w_sh_b  = r_mem_rdata >> {w_off_b, 3'b000};
    assign w_sh_h  = r_mem_rdata >> {w_off_h, 3'b000};
    assign w_sh_w  = r_mem_rdata >> {w_off_w, 3'b000};
    assign w_byte  = w_sh_b[7:0];
    assign w_half  = w_sh_h[15:0];
    assign w_word  = w_sh_w[31:0];

    // Load extension; on XLEN=32 the word lane is the whole word, so LD/LWU fall out as LW
    always_comb begin
        w_load = XLEN'(signed'(w_word));
        case (r_load_type)
            3'b000:  w_load = XLEN'(signed'(w_byte));
            3'b001:  w_load = XLEN'(signed'(w_half));
            3'b011:  w_load = r_mem_rdata;
            3'b100:  w_load = XLEN'(w_byte);
            3'b101:  w_load = XLEN'(w_half);
            3'b110:  w_load = XLEN'(w_word);
            default: w_load = XLEN'(signed'(w_word));
        endcase
    end

    // Write-back source select
    always_comb begin
        w_wdata = r_alu_result;
        case (r_wb_sel)
            2'b01:   w_wdata = w_load;
            2'b10:   w_wdata = r_pc_plus4;
            2'b11:   w_wdata = r_csr_rdata;
            default: w_wdata = r_alu_result;
        endcase
    end

    assign w_we     = r_valid && r_reg_write && (r_rd != '0);
    assign rf_we    = w_we;
    assign rf_waddr = r_rd;
    assign rf_wdata = w_wdata;

    // Bypass hold: remember the write for exactly one cycle; flush kills the valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_valid <= 1'b0;
            r_byp_addr  <= '0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= w_we && !flush;
            if (w_we) begin
                r_byp_addr <= r_rd;
                r_byp_data <= w_wdata;
            end
        end
    end

    assign byp_valid = r_byp_valid;
    assign byp_addr  = r_byp_addr;
    assign byp_data  = r_byp_data;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] r_instret;

    // Retire counter: every valid bundle counts, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign instret = r_instret;
`else
    logic w_unused_cnt_width;
    assign w_unused_cnt_width = (CNT_WIDTH != 0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: one XLEN=32 instance (CNT_WIDTH=4 for wrap)
// and one XLEN=64 instance sharing control inputs.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [63:0] mem_rdata;
    logic [63:0] alu_result;
    logic [63:0] pc_plus4;
    logic [63:0] csr_rdata;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [4:0]  rd_addr;
    logic        reg_write;

    logic        in_ready32, rf_we32, byp_valid32;
    logic [4:0]  rf_waddr32, byp_addr32;
    logic [31:0] rf_wdata32, byp_data32;

    logic        unused_in_ready64, unused_byp_valid64;
    logic        rf_we64;
    logic [4:0]  rf_waddr64, unused_byp_addr64;
    logic [63:0] rf_wdata64, unused_byp_data64;

`ifdef WB_RETIRE_CNT_EN
    logic [3:0]  instret32;
    logic [63:0] unused_instret64;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) u32 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .stall      (stall),
        .flush      (flush),
        .mem_rdata  (mem_rdata[31:0]),
        .alu_result (alu_result[31:0]),
        .pc_plus4   (pc_plus4[31:0]),
        .csr_rdata  (csr_rdata[31:0]),
        .wb_sel     (wb_sel),
        .load_type  (load_type),
        .rd_addr    (rd_addr),
        .reg_write  (reg_write),
        .rf_we      (rf_we32),
        .rf_waddr   (rf_waddr32),
        .rf_wdata   (rf_wdata32),
        .byp_valid  (byp_valid32),
        .byp_addr   (byp_addr32),
        .byp_data   (byp_data32)
`ifdef WB_RETIRE_CNT_EN
        ,
        .instret    (instret32)
`endif
    );

    wb_stage #(.XLEN(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(64)) u64 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (unused_in_ready64),
        .stall      (stall),
        .flush      (flush),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .csr_rdata  (csr_rdata),
        .wb_sel     (wb_sel),
        .load_type  (load_type),
        .rd_addr    (rd_addr),
        .reg_write  (reg_write),
        .rf_we      (rf_we64),
        .rf_waddr   (rf_waddr64),
        .rf_wdata   (rf_wdata64),
        .byp_valid  (unused_byp_valid64),
        .byp_addr   (unused_byp_addr64),
        .byp_data   (unused_byp_data64)
`ifdef WB_RETIRE_CNT_EN
        ,
        .instret    (unused_instret64)
`endif
    );

    // XLEN=32 load vectors on mem_rdata = 0x8899AABB
    logic [2:0]  v32_lt  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b011, 3'b110, 3'b111};
    logic [63:0] v32_off [9] = '{64'd2, 64'd2, 64'd3, 64'd1, 64'd0, 64'd1, 64'd0, 64'd2, 64'd0};
    logic [31:0] v32_exp [9] = '{32'hFFFF_FF99, 32'h0000_0099, 32'hFFFF_8899, 32'h0000_AABB,
                                 32'hFFFF_FFBB, 32'h8899_AABB, 32'h8899_AABB, 32'h8899_AABB,
                                 32'h8899_AABB};

    // XLEN=64 load vectors on mem_rdata = 0x80000000_7FFFFFFF
    logic [2:0]  v64_lt  [9] = '{3'b010, 3'b110, 3'b011, 3'b000, 3'b001, 3'b101, 3'b010, 3'b100, 3'b001};
    logic [63:0] v64_off [9] = '{64'd4, 64'd4, 64'd0, 64'd7, 64'd0, 64'd3, 64'd1, 64'd4, 64'd6};
    logic [63:0] v64_exp [9] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                                 64'h8000_0000_7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FF80,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_7FFF,
                                 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0000,
                                 64'hFFFF_FFFF_FFFF_8000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic bundle(input logic [1:0] sel, input logic [2:0] lt, input logic [4:0] rd,
                          input logic we, input logic [63:0] mem, input logic [63:0] alu,
                          input logic [63:0] pc, input logic [63:0] csr);
        wb_sel     = sel;
        load_type  = lt;
        rd_addr    = rd;
        reg_write  = we;
        mem_rdata  = mem;
        alu_result = alu;
        pc_plus4   = pc;
        csr_rdata  = csr;
        in_valid   = 1'b1;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bundle(2'b11, 3'b000, 5'd7, 1'b1, 64'h1, 64'h2, 64'h3, 64'h4);
        rst = 1'b1;
        step();
        step();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we32); end
        n_checks++; if (rf_waddr32 !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d expected 0", rf_waddr32); end
        n_checks++; if (rf_wdata32 !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata32); end
        n_checks++; if (byp_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_byp_valid: got %0b expected 0", byp_valid32); end
        n_checks++; if (byp_addr32 !== 5'd0) begin n_fail++; $display("FAIL reset_byp_addr: got %0d expected 0", byp_addr32); end
        n_checks++; if (byp_data32 !== 32'd0) begin n_fail++; $display("FAIL reset_byp_data: got %h expected 0", byp_data32); end
        n_checks++; if (rf_wdata64 !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wdata64: got %h expected 0", rf_wdata64); end
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready32); end
`ifdef WB_RETIRE_CNT_EN
        n_checks++; if (instret32 !== 4'd0) begin n_fail++; $display("FAIL reset_instret: got %0d expected 0", instret32); end
`endif
        rst = 1'b0;
        idle();
        step();
    endtask

    task automatic test_load32();
        for (int i = 0; i < 9; i++) begin
            bundle(2'b01, v32_lt[i], 5'd5, 1'b1, 64'h8899_AABB, v32_off[i], 64'h0, 64'h0);
            step();
            idle();
            n_checks++; if (rf_we32 !== 1'b1) begin n_fail++; $display("FAIL load32_we[%0d]: got %0b expected 1", i, rf_we32); end
            n_checks++; if (rf_waddr32 !== 5'd5) begin n_fail++; $display("FAIL load32_waddr[%0d]: got %0d expected 5", i, rf_waddr32); end
            n_checks++; if (rf_wdata32 !== v32_exp[i]) begin n_fail++; $display("FAIL load32_wdata[%0d]: got %h expected %h", i, rf_wdata32, v32_exp[i]); end
        end
        step();
    endtask

    task automatic test_load64();
        for (int i = 0; i < 9; i++) begin
            bundle(2'b01, v64_lt[i], 5'd12, 1'b1, 64'h8000_0000_7FFF_FFFF, v64_off[i], 64'h0, 64'h0);
            step();
            idle();
            n_checks++; if (rf_we64 !== 1'b1) begin n_fail++; $display("FAIL load64_we[%0d]: got %0b expected 1", i, rf_we64); end
            n_checks++; if (rf_waddr64 !== 5'd12) begin n_fail++; $display("FAIL load64_waddr[%0d]: got %0d expected 12", i, rf_waddr64); end
            n_checks++; if (rf_wdata64 !== v64_exp[i]) begin n_fail++; $display("FAIL load64_wdata[%0d]: got %h expected %h", i, rf_wdata64, v64_exp[i]); end
        end
        step();
    endtask

    task automatic test_sel_bypass();
        bundle(2'b10, 3'b000, 5'd1, 1'b1, 64'h0, 64'h77, 64'h104, 64'h0);
        step();
        bundle(2'b00, 3'b000, 5'd0, 1'b1, 64'h0, 64'h55, 64'h0, 64'h0);
        n_checks++; if (rf_we32 !== 1'b1) begin n_fail++; $display("FAIL pc4_we: got %0b expected 1", rf_we32); end
        n_checks++; if (rf_wdata32 !== 32'h104) begin n_fail++; $display("FAIL pc4_wdata: got %h expected 00000104", rf_wdata32); end
        n_checks++; if (rf_waddr32 !== 5'd1) begin n_fail++; $display("FAIL pc4_waddr: got %0d expected 1", rf_waddr32); end
        step();
        idle();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0b expected 0", rf_we32); end
        n_checks++; if (byp_valid32 !== 1'b1) begin n_fail++; $display("FAIL byp_valid: got %0b expected 1", byp_valid32); end
        n_checks++; if (byp_addr32 !== 5'd1) begin n_fail++; $display("FAIL byp_addr: got %0d expected 1", byp_addr32); end
        n_checks++; if (byp_data32 !== 32'h104) begin n_fail++; $display("FAIL byp_data: got %h expected 00000104", byp_data32); end
        step();
        n_checks++; if (byp_valid32 !== 1'b0) begin n_fail++; $display("FAIL byp_expire: got %0b expected 0", byp_valid32); end
        bundle(2'b11, 3'b000, 5'd3, 1'b1, 64'h0, 64'h0, 64'h0, 64'hCAFE_F00D);
        step();
        bundle(2'b00, 3'b000, 5'd4, 1'b0, 64'h0, 64'h1234, 64'h0, 64'h0);
        n_checks++; if (rf_wdata32 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL csr_wdata: got %h expected cafef00d", rf_wdata32); end
        step();
        idle();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL no_regwrite_we: got %0b expected 0", rf_we32); end
        n_checks++; if (rf_wdata32 !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h expected 00001234", rf_wdata32); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [3] = '{5'd2, 5'd3, 5'd4};
        logic [31:0] alus [3] = '{32'h10, 32'h20, 32'h30};
        for (int i = 0; i < 3; i++) begin
            bundle(2'b00, 3'b000, rds[i], 1'b1, 64'h0, {32'h0, alus[i]}, 64'h0, 64'h0);
            step();
            n_checks++; if (rf_we32 !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d]: got %0b expected 1", i, rf_we32); end
            n_checks++; if (rf_waddr32 !== rds[i]) begin n_fail++; $display("FAIL b2b_waddr[%0d]: got %0d expected %0d", i, rf_waddr32, rds[i]); end
            n_checks++; if (rf_wdata32 !== alus[i]) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", i, rf_wdata32, alus[i]); end
            if (i > 0) begin
                n_checks++; if (byp_valid32 !== 1'b1) begin n_fail++; $display("FAIL b2b_byp_valid[%0d]: got %0b expected 1", i, byp_valid32); end
                n_checks++; if (byp_addr32 !== rds[i-1]) begin n_fail++; $display("FAIL b2b_byp_addr[%0d]: got %0d expected %0d", i, byp_addr32, rds[i-1]); end
                n_checks++; if (byp_data32 !== alus[i-1]) begin n_fail++; $display("FAIL b2b_byp_data[%0d]: got %h expected %h", i, byp_data32, alus[i-1]); end
            end
        end
        idle();
        step();
        step();
    endtask

    task automatic test_stall();
        pulse_reset();
        bundle(2'b00, 3'b000, 5'd8, 1'b1, 64'h0, 64'h88, 64'h0, 64'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, in_ready32); end
            n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL stall_we[%0d]: got %0b expected 0", i, rf_we32); end
        end
        stall = 1'b0;
        #1;
        n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b expected 1", in_ready32); end
        step();
        idle();
        n_checks++; if (rf_we32 !== 1'b1) begin n_fail++; $display("FAIL release_we: got %0b expected 1", rf_we32); end
        n_checks++; if (rf_waddr32 !== 5'd8) begin n_fail++; $display("FAIL release_waddr: got %0d expected 8", rf_waddr32); end
        step();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL release_single_write: got %0b expected 0", rf_we32); end
        step();
`ifdef WB_RETIRE_CNT_EN
        n_checks++; if (instret32 !== 4'd1) begin n_fail++; $display("FAIL stall_instret: got %0d expected 1", instret32); end
`endif
    endtask

    task automatic test_flush();
        pulse_reset();
        bundle(2'b00, 3'b000, 5'd6, 1'b1, 64'h0, 64'h66, 64'h0, 64'h0);
        step();
        bundle(2'b00, 3'b000, 5'd9, 1'b1, 64'h0, 64'h99, 64'h0, 64'h0);
        flush = 1'b1;
        #1;
        n_checks++; if (rf_we32 !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_we: got %0b expected 1", rf_we32); end
        n_checks++; if (rf_waddr32 !== 5'd6) begin n_fail++; $display("FAIL flush_cycle_waddr: got %0d expected 6", rf_waddr32); end
        step();
        idle();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL flush_drops_capture: got %0b expected 0", rf_we32); end
        n_checks++; if (byp_valid32 !== 1'b0) begin n_fail++; $display("FAIL flush_byp_valid: got %0b expected 0", byp_valid32); end
`ifdef WB_RETIRE_CNT_EN
        n_checks++; if (instret32 !== 4'd1) begin n_fail++; $display("FAIL flush_instret: got %0d expected 1", instret32); end
`endif
        step();
    endtask

    task automatic test_wrap_and_reset();
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            bundle(2'b00, 3'b000, 5'(i + 1), 1'b1, 64'h0, 64'(i), 64'h0, 64'h0);
            step();
        end
        idle();
        step();
`ifdef WB_RETIRE_CNT_EN
        n_checks++; if (instret32 !== 4'd1) begin n_fail++; $display("FAIL wrap_instret: got %0d expected 1", instret32); end
`endif
        bundle(2'b00, 3'b000, 5'd10, 1'b1, 64'h0, 64'hA0, 64'h0, 64'h0);
        step();
        bundle(2'b00, 3'b000, 5'd11, 1'b1, 64'h0, 64'hB0, 64'h0, 64'h0);
        rst = 1'b1;
        step();
        n_checks++; if (rf_we32 !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %0b expected 0", rf_we32); end
        n_checks++; if (byp_valid32 !== 1'b0) begin n_fail++; $display("FAIL midrst_byp_valid: got %0b expected 0", byp_valid32); end
`ifdef WB_RETIRE_CNT_EN
        n_checks++; if (instret32 !== 4'd0) begin n_fail++; $display("FAIL midrst_instret: got %0d expected 0", instret32); end
`endif
        rst = 1'b0;
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        mem_rdata  = '0;
        alu_result = '0;
        pc_plus4   = '0;
        csr_rdata  = '0;
        wb_sel     = '0;
        load_type  = '0;
        rd_addr    = '0;
        reg_write  = 1'b0;
        test_reset();
        test_load32();
        test_load64();
        test_sel_bypass();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered, parametrised write-back stage for the RISC-V pipeline. It captures the MEM-stage result bundle and selects one of four sources: ALU, load data, PC+4 or CSR. Load data is byte/half/word aligned and sign- or zero-extended. The stage drives the register-file write port and holds the last committed write for one extra cycle as a bypass source for ID/EX.

## Interface

- XLEN, 32: datapath width; 32 or 64 only.
- REG_ADDR_WIDTH, 5: register address width.
- CNT_WIDTH, 64: retire counter width (used only with WB_RETIRE_CNT_EN).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM bundle valid.
- in_ready  out  1  stage accepts bundle; equals !stall.
- stall  in  1  downstream hold; blocks capture.
- flush  in  1  kill registered bundle and bypass hold.
- mem_rdata  in  XLEN  raw data-memory read word.
- alu_result  in  XLEN  ALU result; low OFF_W bits are the load byte offset (OFF_W = log2(XLEN/8)).
- pc_plus4  in  XLEN  link value.
- csr_rdata  in  XLEN  CSR read value.
- wb_sel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 CSR.
- load_type  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is treated as LW.
- rd_addr  in  REG_ADDR_WIDTH  destination register.
- reg_write  in  1  bundle writes rd.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_WIDTH  write address.
- rf_wdata  out  XLEN  write data.
- byp_valid  out  1  hold register valid.
- byp_addr  out  REG_ADDR_WIDTH  held address.
- byp_data  out  XLEN  held data.
- instret  out  CNT_WIDTH  retired-bundle count (macro only).

## Operation

- Capture: on the clock edge with in_valid && in_ready, all inputs are latched into the stage register and v_q <= 1.
- Otherwise v_q <= 0. The stage never re-presents a bundle, so no write is duplicated.
- Write-back: rf_we = v_q && reg_write_q && rd_q != 0. Writes to x0 are suppressed.
- rf_waddr = rd_q. rf_wdata = the selected source, computed combinationally from registered fields.
- Load alignment uses off = alu_result_q[OFF_W-1:0]:
  - Byte: byte lane off.
  - Half: lane off & ~1; off[0] is ignored.
  - Word: lane off & ~3.
  - Misaligned addresses are never trapped here.
- Load extension:
  - LB/LH/LW sign-extend to XLEN.
  - LBU/LHU/LWU zero-extend.
  - LD returns the full word when XLEN=64. When XLEN=32, LD and LWU behave as LW.
- Bypass hold: on each cycle with rf_we=1, byp_addr/byp_data <= rf_waddr/rf_wdata and byp_valid <= 1. Otherwise byp_valid <= 0. The hold lasts exactly one cycle after the write.
- flush: next edge forces v_q <= 0 and byp_valid <= 0, and takes priority over capture. A write presented in the same cycle as flush is still performed.
- stall and in_valid together: nothing captured. The upstream bundle must stay stable until accepted.

## Timing

- Latency: accept at edge N, so rf_we/rf_wdata are valid during cycle N..N+1 and byp_* are valid during the following cycle.
- in_ready is combinational from stall only.
- rf_wdata/rf_waddr are don't-care when rf_we=0, but must be deterministic (no X) after reset.
- Reset values:
  - v_q=0, hence rf_we=0.
  - rf_waddr=0, rf_wdata=0.
  - byp_valid=0, byp_addr=0, byp_data=0.
  - instret=0.
  - All stage-register fields=0.
- Reset mid-operation: any captured bundle is discarded and no write occurs in the cycle after reset is asserted. rst has priority over flush and capture.
- Back-to-back accepts: one bundle per cycle sustained. The bypass then holds the previous write while rf_* shows the current one.

## Configuration

- WB_RETIRE_CNT_EN defined: instret is present. It increments by 1 on every cycle with v_q=1, including reg_write=0 and rd=x0 bundles. It does not increment for flushed bundles and wraps modulo 2^CNT_WIDTH.
- WB_RETIRE_CNT_EN undefined: instret port and counter are absent. CNT_WIDTH is unused.

## Test plan

- XLEN=32, mem_rdata=0x8899AABB, alu_result low bits=2, LB, wb_sel=01, rd=5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xFFFFFF99. With LBU: 0x00000099. With LH at off=3: 0xFFFF8899.
- XLEN=64, mem_rdata=0x80000000_7FFFFFFF: LW off=4 → 0xFFFFFFFF_80000000; LWU off=4 → 0x00000000_80000000; LD → the input word unchanged.
- wb_sel=10, pc_plus4=0x104, rd=1, then rd=0 with alu=0x55 → first cycle rf_wdata=0x104 and rf_we=1. Next cycle rf_we=0 and byp_valid=1, byp_addr=1, byp_data=0x104.
- stall=1 with in_valid=1 for 3 cycles → in_ready=0 and rf_we=0 for those cycles. On release, exactly one write occurs and instret advances by 1 (macro on).
- Bundle accepted, then flush asserted the next cycle → the write still occurs that cycle, byp_valid=0 afterwards, and instret counts 1.
- Counter wrap: CNT_WIDTH=4, 17 accepted bundles → instret=1. Asserting rst mid-stream → rf_we=0, byp_valid=0 and instret=0 on the following cycle.
